// File: rtl/clock_pkg.sv
// Shared mode encodings and BCD limits for the clock display controller.
package clock_pkg;

    typedef enum logic [1:0] {
        MODE_RUN     = 2'd0,
        MODE_SET_HR  = 2'd1,
        MODE_SET_MIN = 2'd2
    } mode_e;

    localparam int         DIGIT_W   = 4;
    localparam logic [7:0] SEC_MAX   = 8'h59;
    localparam logic [7:0] MIN_MAX   = 8'h59;
    localparam logic [7:0] HR_MIN_24 = 8'h00;
    localparam logic [7:0] HR_MAX_24 = 8'h23;
    localparam logic [7:0] HR_MAX_12 = 8'h12;
    localparam logic [7:0] HR_MIN_12 = 8'h01;

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter running MIN_VAL..MAX_VAL with wrap strobe.
module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter logic [7:0] MIN_VAL = 8'h00,
    parameter logic [7:0] MAX_VAL = 8'h59,
    parameter logic [7:0] RST_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    input  logic       load,
    output logic [7:0] value,
    output logic       wrap
);

    logic [DIGIT_W-1:0] ones;
    logic [DIGIT_W-1:0] tens;
    logic [7:0]         nxt;

    assign ones = value[DIGIT_W-1:0];
    assign tens = value[7:DIGIT_W];
    assign wrap = inc && (value == MAX_VAL);

    always_comb begin
        nxt = value;
        if (value == MAX_VAL)
            nxt = MIN_VAL;
        else if (ones == 4'd9)
            nxt = {tens + 4'd1, 4'd0};
        else
            nxt = {tens, ones + 4'd1};
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            value <= RST_VAL;
        else if (load)
            value <= MIN_VAL;
        else if (inc)
            value <= nxt;
    end

endmodule

// File: rtl/clock_display_ctrl.sv
// BCD timekeeper with hour/minute set mode feeding the 4-digit display mux.
module clock_display_ctrl
    import clock_pkg::*;
#(
    parameter bit TWELVE_HR    = 1'b0,
    parameter bit BLANK_ON_SET = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick_1hz,
    input  logic        tick_blink,
    input  logic        btn_mode,
    input  logic        btn_inc,
    output logic [15:0] bcd,
    output logic [3:0]  digit_blank,
    output logic        colon,
    output logic [1:0]  mode,
    output logic [7:0]  sec_bcd
);

    localparam logic [7:0] HR_LO  = TWELVE_HR ? HR_MIN_12 : HR_MIN_24;
    localparam logic [7:0] HR_HI  = TWELVE_HR ? HR_MAX_12 : HR_MAX_24;
    localparam logic [7:0] HR_RST = TWELVE_HR ? HR_MAX_12 : HR_MIN_24;

    mode_e      state;
    mode_e      state_nxt;
    logic       blink_phase;
    logic [7:0] min_bcd;
    logic [7:0] hr_bcd;
    logic       sec_wrap;
    logic       min_wrap;
    logic       unused_day_wrap;
    logic       edit_inc;
    logic       sec_inc;
    logic       min_inc;
    logic       hr_inc;
    logic       sec_clr;

    // A mode press swallows a coincident increment press.
    assign edit_inc = btn_inc && !btn_mode;
    assign sec_inc  = (state == MODE_RUN) && tick_1hz;
    assign min_inc  = ((state == MODE_RUN) && sec_wrap)
                   || ((state == MODE_SET_MIN) && edit_inc);
    assign hr_inc   = ((state == MODE_RUN) && min_wrap)
                   || ((state == MODE_SET_HR) && edit_inc);
    assign sec_clr  = (state == MODE_SET_MIN) && btn_mode;

    bcd_mod_counter #(
        .MIN_VAL (8'h00),
        .MAX_VAL (SEC_MAX),
        .RST_VAL (8'h00)
    ) u_sec (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (sec_inc),
        .load  (sec_clr),
        .value (sec_bcd),
        .wrap  (sec_wrap)
    );

    bcd_mod_counter #(
        .MIN_VAL (8'h00),
        .MAX_VAL (MIN_MAX),
        .RST_VAL (8'h00)
    ) u_min (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (min_inc),
        .load  (1'b0),
        .value (min_bcd),
        .wrap  (min_wrap)
    );

    bcd_mod_counter #(
        .MIN_VAL (HR_LO),
        .MAX_VAL (HR_HI),
        .RST_VAL (HR_RST)
    ) u_hr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (hr_inc),
        .load  (1'b0),
        .value (hr_bcd),
        .wrap  (unused_day_wrap)
    );

    always_comb begin
        state_nxt = MODE_RUN;
        case (state)
            MODE_RUN:     state_nxt = btn_mode ? MODE_SET_HR  : MODE_RUN;
            MODE_SET_HR:  state_nxt = btn_mode ? MODE_SET_MIN : MODE_SET_HR;
            MODE_SET_MIN: state_nxt = btn_mode ? MODE_RUN     : MODE_SET_MIN;
            default:      state_nxt = MODE_RUN;
        endcase
    end

    // Blink restarts visible on every mode change.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= MODE_RUN;
            blink_phase <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state)
                blink_phase <= 1'b0;
            else if (tick_blink)
                blink_phase <= !blink_phase;
        end
    end

    always_comb begin
        digit_blank = 4'b0000;
        colon       = !sec_bcd[0];
        case (state)
            MODE_SET_HR: begin
                colon = 1'b1;
                if (BLANK_ON_SET && blink_phase)
                    digit_blank = 4'b1100;
            end
            MODE_SET_MIN: begin
                colon = 1'b1;
                if (BLANK_ON_SET && blink_phase)
                    digit_blank = 4'b0011;
            end
            default: ;
        endcase
    end

    assign bcd  = {hr_bcd, min_bcd};
    assign mode = state;

endmodule

// File: tb/tb_clock_display_ctrl.sv
// Bench for clock_display_ctrl: 24h and 12h instances against an integer time model.
module tb_clock_display_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic tick_1hz;
    logic tick_blink;
    logic btn_mode;
    logic btn_inc;

    logic [15:0] bcd_o   [2];
    logic [3:0]  blank_o [2];
    logic        colon_o [2];
    logic [1:0]  mode_o  [2];
    logic [7:0]  sec_o   [2];

    int n_chk  = 0;
    int n_fail = 0;

    int  hh [2];
    int  mm [2];
    int  ss [2];
    int  md [2];
    bit  bp [2];
    bit  model_ok = 1'b0;

    always #5 clk = ~clk;

    clock_display_ctrl #(.TWELVE_HR(1'b0), .BLANK_ON_SET(1'b1)) dut24 (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick_1hz    (tick_1hz),
        .tick_blink  (tick_blink),
        .btn_mode    (btn_mode),
        .btn_inc     (btn_inc),
        .bcd         (bcd_o[0]),
        .digit_blank (blank_o[0]),
        .colon       (colon_o[0]),
        .mode        (mode_o[0]),
        .sec_bcd     (sec_o[0])
    );

    clock_display_ctrl #(.TWELVE_HR(1'b1), .BLANK_ON_SET(1'b1)) dut12 (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick_1hz    (tick_1hz),
        .tick_blink  (tick_blink),
        .btn_mode    (btn_mode),
        .btn_inc     (btn_inc),
        .bcd         (bcd_o[1]),
        .digit_blank (blank_o[1]),
        .colon       (colon_o[1]),
        .mode        (mode_o[1]),
        .sec_bcd     (sec_o[1])
    );

    function automatic logic [7:0] to_bcd(input int n);
        logic [3:0] t;
        logic [3:0] o;
        t = 4'(n / 10);
        o = 4'(n % 10);
        return {t, o};
    endfunction

    function automatic int hr_next(input int h, input int v);
        if (v == 1)
            return (h == 12) ? 1 : h + 1;
        return (h + 1) % 24;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: wall-clock time as integers, updated from the inputs at each edge.
    always @(posedge clk) begin
        for (int v = 0; v < 2; v++) begin
            int nmd;
            if (!rst_n) begin
                hh[v] = (v == 1) ? 12 : 0;
                mm[v] = 0;
                ss[v] = 0;
                md[v] = 0;
                bp[v] = 1'b0;
            end else begin
                nmd = btn_mode ? (md[v] + 1) % 3 : md[v];
                if (md[v] == 0 && tick_1hz) begin
                    ss[v] = ss[v] + 1;
                    if (ss[v] == 60) begin
                        ss[v] = 0;
                        mm[v] = mm[v] + 1;
                        if (mm[v] == 60) begin
                            mm[v] = 0;
                            hh[v] = hr_next(hh[v], v);
                        end
                    end
                end
                if (md[v] == 1 && btn_inc && !btn_mode)
                    hh[v] = hr_next(hh[v], v);
                if (md[v] == 2 && btn_inc && !btn_mode)
                    mm[v] = (mm[v] + 1) % 60;
                if (md[v] == 2 && btn_mode)
                    ss[v] = 0;
                if (nmd != md[v])
                    bp[v] = 1'b0;
                else if (tick_blink)
                    bp[v] = !bp[v];
                md[v] = nmd;
            end
        end
        if (!rst_n)
            model_ok = 1'b1;
    end

    always @(negedge clk) begin
        if (model_ok) begin
            for (int v = 0; v < 2; v++) begin
                logic [3:0] eb;
                logic       ec;
                eb = 4'b0000;
                if (md[v] == 1 && bp[v]) eb = 4'b1100;
                if (md[v] == 2 && bp[v]) eb = 4'b0011;
                ec = (md[v] != 0) ? 1'b1 : ((ss[v] % 10) % 2 == 0);
                chk($sformatf("bcd[%0d]", v), 32'(bcd_o[v]),
                    32'({to_bcd(hh[v]), to_bcd(mm[v])}));
                chk($sformatf("sec[%0d]", v), 32'(sec_o[v]), 32'(to_bcd(ss[v])));
                chk($sformatf("mode[%0d]", v), 32'(mode_o[v]), 32'(md[v]));
                chk($sformatf("blank[%0d]", v), 32'(blank_o[v]), 32'(eb));
                chk($sformatf("colon[%0d]", v), 32'(colon_o[v]), 32'(ec));
            end
        end
    end

    task automatic step(input bit t, input bit b, input bit m, input bit i);
        @(negedge clk);
        tick_1hz   = t;
        tick_blink = b;
        btn_mode   = m;
        btn_inc    = i;
        @(negedge clk);
        tick_1hz   = 1'b0;
        tick_blink = 1'b0;
        btn_mode   = 1'b0;
        btn_inc    = 1'b0;
    endtask

    logic [3:0] blink_seq [4] = '{4'b1100, 4'b0000, 4'b1100, 4'b0000};

    initial begin
        rst_n      = 1'b0;
        tick_1hz   = 1'b0;
        tick_blink = 1'b0;
        btn_mode   = 1'b0;
        btn_inc    = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_bcd24", 32'(bcd_o[0]), 32'h0000);
        chk("rst_bcd12", 32'(bcd_o[1]), 32'h1200);
        chk("rst_mode", 32'(mode_o[0]), 32'd0);
        chk("rst_blank", 32'(blank_o[0]), 32'h0);
        chk("rst_colon", 32'(colon_o[0]), 32'd1);
        rst_n = 1'b1;

        repeat (59) step(1, 0, 0, 0);
        chk("sec59", 32'(sec_o[0]), 32'h59);
        chk("sec59_bcd", 32'(bcd_o[0]), 32'h0000);
        chk("sec59_colon", 32'(colon_o[0]), 32'd0);
        step(1, 0, 0, 0);
        chk("sec_wrap", 32'(sec_o[0]), 32'h00);
        chk("min_carry", 32'(bcd_o[0]), 32'h0001);
        chk("colon_even", 32'(colon_o[0]), 32'd1);
        repeat (3) step(1, 0, 0, 0);
        chk("sec03", 32'(sec_o[0]), 32'h03);

        step(0, 0, 1, 1);
        chk("mode_inc_mode", 32'(mode_o[0]), 32'd1);
        chk("mode_inc_bcd", 32'(bcd_o[0]), 32'h0001);
        step(1, 0, 0, 0);
        chk("sethr_sec_hold", 32'(sec_o[0]), 32'h03);
        chk("sethr_colon", 32'(colon_o[0]), 32'd1);
        repeat (25) step(0, 0, 0, 1);
        chk("hr25_24", 32'(bcd_o[0]), 32'h0101);
        chk("hr25_12", 32'(bcd_o[1]), 32'h0101);

        for (int k = 0; k < 4; k++) begin
            step(0, 1, 0, 0);
            chk($sformatf("blink%0d", k), 32'(blank_o[0]), 32'(blink_seq[k]));
        end
        step(0, 1, 0, 0);
        chk("blink_on", 32'(blank_o[0]), 32'b1100);
        step(0, 0, 1, 0);
        chk("setmin_mode", 32'(mode_o[0]), 32'd2);
        chk("setmin_shown", 32'(blank_o[0]), 32'b0000);
        step(0, 1, 0, 0);
        chk("setmin_blank", 32'(blank_o[0]), 32'b0011);

        repeat (58) step(0, 0, 0, 1);
        chk("min59", 32'(bcd_o[0]), 32'h0159);
        step(0, 0, 0, 1);
        chk("min_nocarry", 32'(bcd_o[0]), 32'h0100);
        step(0, 0, 1, 0);
        chk("run_mode", 32'(mode_o[0]), 32'd0);
        chk("run_sec_clr", 32'(sec_o[0]), 32'h00);

        step(0, 0, 1, 0);
        repeat (22) step(0, 0, 0, 1);
        step(0, 0, 1, 0);
        repeat (59) step(0, 0, 0, 1);
        step(0, 0, 1, 0);
        chk("pre_2359", 32'(bcd_o[0]), 32'h2359);
        chk("pre_1159", 32'(bcd_o[1]), 32'h1159);
        repeat (60) step(1, 0, 0, 0);
        chk("day_wrap24", 32'(bcd_o[0]), 32'h0000);
        chk("day_wrap_sec", 32'(sec_o[0]), 32'h00);
        chk("wrap_11_12", 32'(bcd_o[1]), 32'h1200);

        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        repeat (59) step(0, 0, 0, 1);
        step(0, 0, 1, 0);
        chk("pre_1259", 32'(bcd_o[1]), 32'h1259);
        repeat (60) step(1, 0, 0, 0);
        chk("wrap_12_01", 32'(bcd_o[1]), 32'h0100);
        chk("hr_carry24", 32'(bcd_o[0]), 32'h0100);

        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        repeat (3) step(0, 0, 0, 1);
        chk("pre_rst_mode", 32'(mode_o[0]), 32'd2);
        @(negedge clk);
        rst_n   = 1'b0;
        btn_inc = 1'b1;
        @(negedge clk);
        rst_n   = 1'b1;
        btn_inc = 1'b0;
        chk("mid_rst_mode", 32'(mode_o[0]), 32'd0);
        chk("mid_rst_bcd", 32'(bcd_o[0]), 32'h0000);
        chk("mid_rst_blank", 32'(blank_o[0]), 32'h0);
        chk("mid_rst_colon", 32'(colon_o[0]), 32'd1);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
